// File: rtl/idex_pipe_reg_pkg.sv
// Shared decode/execute types: control-field encodings, the NOP defaults and
// the packed ID/EX bundle that the pipeline latch stores as one register.
package control_unit_types_pkg;

    typedef enum logic [3:0] {
        OPFUNC_NOP  = 4'd0,
        OPFUNC_ADD  = 4'd1,
        OPFUNC_SUB  = 4'd2,
        OPFUNC_AND  = 4'd3,
        OPFUNC_OR   = 4'd4,
        OPFUNC_LW   = 4'd5,
        OPFUNC_SW   = 4'd6,
        OPFUNC_BEQ  = 4'd7,
        OPFUNC_J    = 4'd8,
        OPFUNC_HALT = 4'd9
    } opfunc_t;

    typedef enum logic [1:0] {
        REGDST_RT = 2'd0,
        REGDST_RD = 2'd1,
        REGDST_RA = 2'd2
    } regdst_t;

    typedef enum logic [1:0] {
        MEMTOREG_ALU = 2'd0,
        MEMTOREG_MEM = 2'd1,
        MEMTOREG_NPC = 2'd2
    } memtoreg_t;

    typedef enum logic [3:0] {
        ALUOP_ADD = 4'd0,
        ALUOP_SUB = 4'd1,
        ALUOP_AND = 4'd2,
        ALUOP_OR  = 4'd3,
        ALUOP_XOR = 4'd4,
        ALUOP_SLT = 4'd5,
        ALUOP_SLL = 4'd6,
        ALUOP_SRL = 4'd7
    } aluop_t;

    typedef enum logic {
        EXTOP_ZERO = 1'b0,
        EXTOP_SIGN = 1'b1
    } extop_t;

    // Pending-flush tracker state for the latch controller.
    typedef enum logic {
        PEND_IDLE  = 1'b0,
        PEND_ARMED = 1'b1
    } pend_state_t;

    // Control defaults carried by an inserted bubble. All are the zero
    // encoding, so the reset image and the NOP image are identical.
    localparam regdst_t   NOP_REGDST   = REGDST_RT;
    localparam memtoreg_t NOP_MEMTOREG = MEMTOREG_ALU;
    localparam aluop_t    NOP_ALUOP    = ALUOP_ADD;
    localparam extop_t    NOP_EXTOP    = EXTOP_ZERO;

    typedef struct packed {
        opfunc_t     opfunc;
        regdst_t     regdst;
        memtoreg_t   memtoreg;
        logic        alusrc;
        logic        regwen;
        logic        dweni;
        logic        dreni;
        aluop_t      aluop;
        extop_t      extop;
        logic        halt;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [31:0] busa;
        logic [31:0] busb;
        logic [31:0] npc;
    } idex_bundle_t;

    function automatic idex_bundle_t nop_bundle();
        idex_bundle_t b;
        b          = '0;
        b.opfunc   = OPFUNC_NOP;
        b.regdst   = NOP_REGDST;
        b.memtoreg = NOP_MEMTOREG;
        b.aluop    = NOP_ALUOP;
        b.extop    = NOP_EXTOP;
        return b;
    endfunction

endpackage

// File: rtl/idex_pipe_reg_if.sv
// ID->EX stage bus: decode-side fields (id_*) and execute-side fields (ex_*).
// master = decode producer / execute consumer, slave = the pipeline latch.
interface idexpipe_if;
    import control_unit_types_pkg::*;

    opfunc_t     id_opfunc;
    regdst_t     id_RegDst;
    memtoreg_t   id_MemtoReg;
    logic        id_ALUSrc;
    logic        id_RegWEN;
    logic        id_dWENi;
    logic        id_dRENi;
    aluop_t      id_ALUOp;
    extop_t      id_ExtOp;
    logic        id_halt;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm;
    logic [31:0] id_busA;
    logic [31:0] id_busB;
    logic [31:0] id_npc;

    opfunc_t     ex_opfunc;
    regdst_t     ex_RegDst;
    memtoreg_t   ex_MemtoReg;
    logic        ex_ALUSrc;
    logic        ex_RegWEN;
    logic        ex_dWENi;
    logic        ex_dRENi;
    aluop_t      ex_ALUOp;
    extop_t      ex_ExtOp;
    logic        ex_halt;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_shamt;
    logic [15:0] ex_imm;
    logic [31:0] ex_busA;
    logic [31:0] ex_busB;
    logic [31:0] ex_npc;

    modport master (
        output id_opfunc, id_RegDst, id_MemtoReg, id_ALUSrc, id_RegWEN, id_dWENi,
               id_dRENi, id_ALUOp, id_ExtOp, id_halt, id_rt, id_rd, id_shamt,
               id_imm, id_busA, id_busB, id_npc,
        input  ex_opfunc, ex_RegDst, ex_MemtoReg, ex_ALUSrc, ex_RegWEN, ex_dWENi,
               ex_dRENi, ex_ALUOp, ex_ExtOp, ex_halt, ex_rt, ex_rd, ex_shamt,
               ex_imm, ex_busA, ex_busB, ex_npc
    );

    modport slave (
        input  id_opfunc, id_RegDst, id_MemtoReg, id_ALUSrc, id_RegWEN, id_dWENi,
               id_dRENi, id_ALUOp, id_ExtOp, id_halt, id_rt, id_rd, id_shamt,
               id_imm, id_busA, id_busB, id_npc,
        output ex_opfunc, ex_RegDst, ex_MemtoReg, ex_ALUSrc, ex_RegWEN, ex_dWENi,
               ex_dRENi, ex_ALUOp, ex_ExtOp, ex_halt, ex_rt, ex_rd, ex_shamt,
               ex_imm, ex_busA, ex_busB, ex_npc
    );

endinterface

// File: rtl/idex_pipe_reg_pipe_ctl.sv
// Latch controller: decides when the ID/EX latch advances, when it loads a
// NOP, remembers flushes that arrive while frozen, and counts bubbles.
module pipe_ctl
    import control_unit_types_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter bit          FLUSH_MEM = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dmemwait,
    input  logic             flush,
    input  logic             bubble,
    input  logic             halted,
    output logic             adv,
    output logic             load_nop,
    output logic [CNT_W-1:0] bubble_cnt
);

    pend_state_t pend_q;
    pend_state_t pend_d;
    logic        kill;

    // Advance/kill decode and pending-flush next state.
    always_comb begin
        adv      = ihit & ~dmemwait & ~halted;
        kill     = flush | (pend_q == PEND_ARMED);
        load_nop = adv & (kill | bubble);
        pend_d   = pend_q;
        if (adv) begin
            pend_d = PEND_IDLE;
        end else if (flush && FLUSH_MEM) begin
            pend_d = PEND_ARMED;
        end
    end

    // Pending-flush state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= PEND_IDLE;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Saturating count of NOP loads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bubble_cnt <= '0;
        end else if (load_nop && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID->EX pipeline latch. The whole stage is one idex_bundle_t register that
// loads the decode fields or a NOP bundle under control of pipe_ctl.
module idex_pipe_reg
    import control_unit_types_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter bit          FLUSH_MEM = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dmemwait,
    input  logic             flush,
    input  logic             bubble,
    idexpipe_if.slave        bus,
    output logic             ex_valid,
    output logic [CNT_W-1:0] bubble_cnt
);

    idex_bundle_t id_d;
    idex_bundle_t ex_q;
    logic         adv;
    logic         load_nop;

    pipe_ctl #(
        .CNT_W     (CNT_W),
        .FLUSH_MEM (FLUSH_MEM)
    ) u_ctl (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dmemwait   (dmemwait),
        .flush      (flush),
        .bubble     (bubble),
        .halted     (ex_q.halt),
        .adv        (adv),
        .load_nop   (load_nop),
        .bubble_cnt (bubble_cnt)
    );

    // Gather the decode-side fields into one bundle.
    always_comb begin
        id_d          = '0;
        id_d.opfunc   = bus.id_opfunc;
        id_d.regdst   = bus.id_RegDst;
        id_d.memtoreg = bus.id_MemtoReg;
        id_d.alusrc   = bus.id_ALUSrc;
        id_d.regwen   = bus.id_RegWEN;
        id_d.dweni    = bus.id_dWENi;
        id_d.dreni    = bus.id_dRENi;
        id_d.aluop    = bus.id_ALUOp;
        id_d.extop    = bus.id_ExtOp;
        id_d.halt     = bus.id_halt;
        id_d.rt       = bus.id_rt;
        id_d.rd       = bus.id_rd;
        id_d.shamt    = bus.id_shamt;
        id_d.imm      = bus.id_imm;
        id_d.busa     = bus.id_busA;
        id_d.busb     = bus.id_busB;
        id_d.npc      = bus.id_npc;
    end

    // Stage register: hold when frozen, otherwise load NOP or decode bundle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q     <= nop_bundle();
            ex_valid <= 1'b0;
        end else if (adv) begin
            if (load_nop) begin
                ex_q     <= nop_bundle();
                ex_valid <= 1'b0;
            end else begin
                ex_q     <= id_d;
                ex_valid <= 1'b1;
            end
        end
    end

    assign bus.ex_opfunc   = ex_q.opfunc;
    assign bus.ex_RegDst   = ex_q.regdst;
    assign bus.ex_MemtoReg = ex_q.memtoreg;
    assign bus.ex_ALUSrc   = ex_q.alusrc;
    assign bus.ex_RegWEN   = ex_q.regwen;
    assign bus.ex_dWENi    = ex_q.dweni;
    assign bus.ex_dRENi    = ex_q.dreni;
    assign bus.ex_ALUOp    = ex_q.aluop;
    assign bus.ex_ExtOp    = ex_q.extop;
    assign bus.ex_halt     = ex_q.halt;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_shamt    = ex_q.shamt;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_busA     = ex_q.busa;
    assign bus.ex_busB     = ex_q.busb;
    assign bus.ex_npc      = ex_q.npc;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg: a default instance (CNT_W=32, FLUSH_MEM=1)
// and a narrow instance (CNT_W=4, FLUSH_MEM=0) for saturation and
// no-flush-memory behaviour.
module tb_idex_pipe_reg;
    import control_unit_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, ihit, dmemwait, flush, bubble;
    logic        ex_valid;
    logic [31:0] bubble_cnt;

    logic        rst4, ihit4, dmemwait4, flush4, bubble4;
    logic        ex_valid4;
    logic [3:0]  bubble_cnt4;

    int passed = 0;
    int total  = 0;

    idexpipe_if bus ();
    idexpipe_if bus4 ();

    idex_pipe_reg #(.CNT_W(32), .FLUSH_MEM(1'b1)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dmemwait(dmemwait), .flush(flush),
        .bubble(bubble), .bus(bus), .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
    );

    idex_pipe_reg #(.CNT_W(4), .FLUSH_MEM(1'b0)) dut4 (
        .CLK(CLK), .RST(rst4), .ihit(ihit4), .dmemwait(dmemwait4), .flush(flush4),
        .bubble(bubble4), .bus(bus4), .ex_valid(ex_valid4), .bubble_cnt(bubble_cnt4)
    );

    always #5 CLK = ~CLK;

    // One rising edge, then settle away from it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_id();
        bus.id_opfunc = OPFUNC_NOP;  bus.id_RegDst = REGDST_RT;  bus.id_MemtoReg = MEMTOREG_ALU;
        bus.id_ALUSrc = 1'b0;        bus.id_RegWEN = 1'b0;       bus.id_dWENi = 1'b0;
        bus.id_dRENi = 1'b0;         bus.id_ALUOp = ALUOP_ADD;   bus.id_ExtOp = EXTOP_ZERO;
        bus.id_halt = 1'b0;          bus.id_rt = '0;             bus.id_rd = '0;
        bus.id_shamt = '0;           bus.id_imm = '0;            bus.id_busA = '0;
        bus.id_busB = '0;            bus.id_npc = '0;
        bus4.id_opfunc = OPFUNC_NOP; bus4.id_RegDst = REGDST_RT; bus4.id_MemtoReg = MEMTOREG_ALU;
        bus4.id_ALUSrc = 1'b0;       bus4.id_RegWEN = 1'b0;      bus4.id_dWENi = 1'b0;
        bus4.id_dRENi = 1'b0;        bus4.id_ALUOp = ALUOP_ADD;  bus4.id_ExtOp = EXTOP_ZERO;
        bus4.id_halt = 1'b0;         bus4.id_rt = '0;            bus4.id_rd = '0;
        bus4.id_shamt = '0;          bus4.id_imm = '0;           bus4.id_busA = '0;
        bus4.id_busB = '0;           bus4.id_npc = '0;
    endtask

    task automatic test_reset();
        bubble = 1'b1;
        step();
        bubble = 1'b0;
        bus.id_busA = 32'h0000_1234; bus.id_RegWEN = 1'b1; bus.id_opfunc = OPFUNC_SUB;
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL t1_pre_valid: got %b expected 1", ex_valid); else passed++;
        total++; if (bubble_cnt !== 32'd1) $display("FAIL t1_pre_cnt: got %0d expected 1", bubble_cnt); else passed++;
        RST = 1'b1;
        #2;
        total++; if (bus.ex_busA !== 32'h0) $display("FAIL t1_busA: got %h expected 0", bus.ex_busA); else passed++;
        total++; if (bus.ex_RegWEN !== 1'b0) $display("FAIL t1_regwen: got %b expected 0", bus.ex_RegWEN); else passed++;
        total++; if (bus.ex_opfunc !== OPFUNC_NOP) $display("FAIL t1_opfunc: got %0d expected 0", bus.ex_opfunc); else passed++;
        total++; if (ex_valid !== 1'b0) $display("FAIL t1_valid: got %b expected 0", ex_valid); else passed++;
        total++; if (bubble_cnt !== 32'd0) $display("FAIL t1_cnt: got %0d expected 0", bubble_cnt); else passed++;
        RST = 1'b0;
    endtask

    task automatic test_pass_through();
        bus.id_busA = 32'hDEAD_BEEF; bus.id_rt = 5'd5; bus.id_RegWEN = 1'b1; bus.id_opfunc = OPFUNC_ADD;
        step();
        total++; if (bus.ex_busA !== 32'hDEAD_BEEF) $display("FAIL t2_busA: got %h expected deadbeef", bus.ex_busA); else passed++;
        total++; if (bus.ex_rt !== 5'd5) $display("FAIL t2_rt: got %0d expected 5", bus.ex_rt); else passed++;
        total++; if (bus.ex_RegWEN !== 1'b1) $display("FAIL t2_regwen: got %b expected 1", bus.ex_RegWEN); else passed++;
        total++; if (bus.ex_opfunc !== OPFUNC_ADD) $display("FAIL t2_opfunc: got %0d expected 1", bus.ex_opfunc); else passed++;
        total++; if (ex_valid !== 1'b1) $display("FAIL t2_valid: got %b expected 1", ex_valid); else passed++;
    endtask

    task automatic test_freeze();
        bus.id_npc = 32'h40;
        step();
        total++; if (bus.ex_npc !== 32'h40) $display("FAIL t3_load: got %h expected 40", bus.ex_npc); else passed++;
        dmemwait = 1'b1; bus.id_npc = 32'h44;
        repeat (3) step();
        total++; if (bus.ex_npc !== 32'h40) $display("FAIL t3_hold: got %h expected 40", bus.ex_npc); else passed++;
        dmemwait = 1'b0;
        step();
        total++; if (bus.ex_npc !== 32'h44) $display("FAIL t3_release: got %h expected 44", bus.ex_npc); else passed++;
        ihit = 1'b0; bus.id_npc = 32'h48;
        step();
        total++; if (bus.ex_npc !== 32'h44) $display("FAIL t3_ihit_hold: got %h expected 44", bus.ex_npc); else passed++;
        ihit = 1'b1;
    endtask

    task automatic test_pending_flush();
        bus.id_npc = 32'h50;
        dmemwait = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        total++; if (bus.ex_npc !== 32'h44) $display("FAIL t4_frozen_npc: got %h expected 44", bus.ex_npc); else passed++;
        total++; if (ex_valid !== 1'b1) $display("FAIL t4_frozen_valid: got %b expected 1", ex_valid); else passed++;
        dmemwait = 1'b0;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL t4_kill_valid: got %b expected 0", ex_valid); else passed++;
        total++; if (bus.ex_RegWEN !== 1'b0) $display("FAIL t4_kill_regwen: got %b expected 0", bus.ex_RegWEN); else passed++;
        total++; if (bubble_cnt !== 32'd1) $display("FAIL t4_kill_cnt: got %0d expected 1", bubble_cnt); else passed++;
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL t4_next_valid: got %b expected 1", ex_valid); else passed++;
        total++; if (bus.ex_npc !== 32'h50) $display("FAIL t4_next_npc: got %h expected 50", bus.ex_npc); else passed++;
    endtask

    task automatic test_flush_bubble();
        flush = 1'b1; bubble = 1'b1;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL t5_both_valid: got %b expected 0", ex_valid); else passed++;
        total++; if (bubble_cnt !== 32'd2) $display("FAIL t5_both_cnt: got %0d expected 2", bubble_cnt); else passed++;
        flush = 1'b0; bus.id_dWENi = 1'b1;
        step();
        total++; if (bus.ex_dWENi !== 1'b0) $display("FAIL t5_bub_dweni: got %b expected 0", bus.ex_dWENi); else passed++;
        total++; if (bubble_cnt !== 32'd3) $display("FAIL t5_bub_cnt: got %0d expected 3", bubble_cnt); else passed++;
        bubble = 1'b0;
        step();
        total++; if (bus.ex_dWENi !== 1'b1) $display("FAIL t5_norm_dweni: got %b expected 1", bus.ex_dWENi); else passed++;
        flush = 1'b1;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL t5_flush_valid: got %b expected 0", ex_valid); else passed++;
        flush = 1'b0;
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL t5_nopend_valid: got %b expected 1", ex_valid); else passed++;
        total++; if (bubble_cnt !== 32'd4) $display("FAIL t5_nopend_cnt: got %0d expected 4", bubble_cnt); else passed++;
        bus.id_dWENi = 1'b0;
    endtask

    task automatic test_halt();
        bus.id_halt = 1'b1; bus.id_npc = 32'h60;
        step();
        total++; if (bus.ex_halt !== 1'b1) $display("FAIL t6_halt_set: got %b expected 1", bus.ex_halt); else passed++;
        bus.id_halt = 1'b0; bus.id_npc = 32'h64; flush = 1'b1; bubble = 1'b1;
        repeat (3) step();
        total++; if (bus.ex_npc !== 32'h60) $display("FAIL t6_hold_npc: got %h expected 60", bus.ex_npc); else passed++;
        total++; if (bus.ex_halt !== 1'b1) $display("FAIL t6_hold_halt: got %b expected 1", bus.ex_halt); else passed++;
        total++; if (ex_valid !== 1'b1) $display("FAIL t6_hold_valid: got %b expected 1", ex_valid); else passed++;
        total++; if (bubble_cnt !== 32'd4) $display("FAIL t6_hold_cnt: got %0d expected 4", bubble_cnt); else passed++;
        flush = 1'b0; bubble = 1'b0;
        RST = 1'b1;
        #2;
        total++; if (bus.ex_halt !== 1'b0) $display("FAIL t6_rst_halt: got %b expected 0", bus.ex_halt); else passed++;
        total++; if (bubble_cnt !== 32'd0) $display("FAIL t6_rst_cnt: got %0d expected 0", bubble_cnt); else passed++;
        RST = 1'b0; bus.id_npc = 32'h70;
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL t6_post_valid: got %b expected 1", ex_valid); else passed++;
        total++; if (bus.ex_npc !== 32'h70) $display("FAIL t6_post_npc: got %h expected 70", bus.ex_npc); else passed++;
    endtask

    task automatic test_saturation();
        rst4 = 1'b0; bubble4 = 1'b1;
        repeat (14) step();
        total++; if (bubble_cnt4 !== 4'd14) $display("FAIL t6_sat14: got %0d expected 14", bubble_cnt4); else passed++;
        step();
        total++; if (bubble_cnt4 !== 4'd15) $display("FAIL t6_sat15: got %0d expected 15", bubble_cnt4); else passed++;
        repeat (5) step();
        total++; if (bubble_cnt4 !== 4'd15) $display("FAIL t6_sat20: got %0d expected 15", bubble_cnt4); else passed++;
        total++; if (ex_valid4 !== 1'b0) $display("FAIL t6_sat_valid: got %b expected 0", ex_valid4); else passed++;
    endtask

    task automatic test_no_flush_mem();
        bubble4 = 1'b0; dmemwait4 = 1'b1; flush4 = 1'b1;
        step();
        flush4 = 1'b0;
        step();
        dmemwait4 = 1'b0; bus4.id_npc = 32'h80; bus4.id_RegWEN = 1'b1;
        step();
        total++; if (ex_valid4 !== 1'b1) $display("FAIL nfm_valid: got %b expected 1", ex_valid4); else passed++;
        total++; if (bus4.ex_npc !== 32'h80) $display("FAIL nfm_npc: got %h expected 80", bus4.ex_npc); else passed++;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b1; dmemwait = 1'b0; flush = 1'b0; bubble = 1'b0;
        rst4 = 1'b1; ihit4 = 1'b1; dmemwait4 = 1'b0; flush4 = 1'b0; bubble4 = 1'b0;
        clear_id();
        repeat (2) step();
        RST = 1'b0;
        test_reset();
        test_pass_through();
        test_freeze();
        test_pending_flush();
        test_flush_bubble();
        test_halt();
        test_saturation();
        test_no_flush_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
